// File: rtl/decoder3to8_pkg.sv
// Shared widths and the one-hot helper for the 3-to-8 decoder slice.
package decoder3to8_pkg;

   localparam int SEL_W     = 3;
   localparam int OUT_W     = 8;
   localparam int CNT_W_DEF = 16;

   function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] s);
      return OUT_W'(1) << s;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/decoder3to8.sv
// 3-to-8 one-hot decoder with a registered enable-gated copy, a select-change
// pulse and a bank of per-line saturating hit counters.
module decoder3to8
   import decoder3to8_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEL_W-1:0] sel,
   output logic [OUT_W-1:0] y,
   input  logic             en,
   input  logic             clr,
   output logic [OUT_W-1:0] y_q,
   output logic             valid_q,
   output logic             change_q,
   input  logic [SEL_W-1:0] cnt_sel,
   output logic [CNT_W-1:0] cnt_out
);

   logic [SEL_W-1:0] last_sel;
   logic             last_empty;
   logic [CNT_W-1:0] cnt [OUT_W];

   assign y = onehot(sel);

   // The first qualified sel after reset only fills last_sel; it never pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q        <= '0;
         valid_q    <= 1'b0;
         change_q   <= 1'b0;
         last_sel   <= '0;
         last_empty <= 1'b1;
      end else begin
         valid_q  <= en;
         y_q      <= en ? onehot(sel) : '0;
         change_q <= en && !last_empty && (sel != last_sel);
         if (en) begin
            last_sel   <= sel;
            last_empty <= 1'b0;
         end
      end
   end

   for (genvar i = 0; i < OUT_W; i++) begin : g_cnt
      sat_counter #(
         .W (CNT_W)
      ) u_cnt (
         .clk (clk),
         .rst (rst),
         .clr (clr),
         .inc (en && (sel == SEL_W'(i))),
         .q   (cnt[i])
      );
   end

   assign cnt_out = cnt[cnt_sel];

endmodule

// File: tb/tb_decoder3to8.sv
// Directed bench for decoder3to8: default-width and 4-bit-counter instances on shared stimulus.
module tb_decoder3to8;

   logic        clk = 1'b0;
   logic        rst, en, clr;
   logic [2:0]  sel, cnt_sel;

   logic [7:0]  y, y_q, y4, y_q4;
   logic        valid_q, change_q, valid_q4, change_q4;
   logic [15:0] cnt_out;
   logic [3:0]  cnt_out4;

   int checks = 0;
   int failures = 0;

   logic [7:0] exp_y [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
   logic       exp_chg [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [2:0] chg_sel [5] = '{3'd2, 3'd2, 3'd6, 3'd6, 3'd1};

   decoder3to8 dut (
      .clk (clk), .rst (rst), .sel (sel), .y (y), .en (en), .clr (clr),
      .y_q (y_q), .valid_q (valid_q), .change_q (change_q),
      .cnt_sel (cnt_sel), .cnt_out (cnt_out)
   );

   decoder3to8 #(.CNT_W (4)) dut4 (
      .clk (clk), .rst (rst), .sel (sel), .y (y4), .en (en), .clr (clr),
      .y_q (y_q4), .valid_q (valid_q4), .change_q (change_q4),
      .cnt_sel (cnt_sel), .cnt_out (cnt_out4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; clr = 1'b0; sel = 3'd0; cnt_sel = 3'd0;

      // combinational sweep before any reset
      for (int s = 0; s < 8; s++) begin
         sel = 3'(s);
         #1;
         chk($sformatf("y_sweep_%0d", s), {24'h0, y}, {24'h0, exp_y[s]});
      end

      // reset state
      rst = 1'b1; sel = 3'd4;
      tick();
      chk("rst_y_q", {24'h0, y_q}, 32'h0);
      chk("rst_valid_q", {31'h0, valid_q}, 32'h0);
      chk("rst_change_q", {31'h0, change_q}, 32'h0);
      chk("rst_y_live", {24'h0, y}, 32'h10);
      for (int i = 0; i < 8; i++) begin
         cnt_sel = 3'(i);
         #1;
         chk($sformatf("rst_cnt_%0d", i), {16'h0, cnt_out}, 32'h0);
      end

      // registered path
      rst = 1'b0; en = 1'b1; sel = 3'd5;
      tick();
      chk("reg_y_q_sel5", {24'h0, y_q}, 32'h20);
      chk("reg_valid_q_1", {31'h0, valid_q}, 32'h1);
      en = 1'b0;
      tick();
      chk("reg_y_q_off", {24'h0, y_q}, 32'h0);
      chk("reg_valid_q_0", {31'h0, valid_q}, 32'h0);

      // counters
      rst = 1'b1;
      tick();
      rst = 1'b0; en = 1'b1; sel = 3'd3;
      repeat (4) tick();
      en = 1'b0;
      cnt_sel = 3'd3; #1;
      chk("cnt3_after4", {16'h0, cnt_out}, 32'd4);
      cnt_sel = 3'd2; #1;
      chk("cnt2_zero", {16'h0, cnt_out}, 32'd0);
      clr = 1'b1; en = 1'b1; sel = 3'd3;
      tick();
      clr = 1'b0; en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cnt_sel = 3'(i);
         #1;
         chk($sformatf("clr_cnt_%0d", i), {16'h0, cnt_out}, 32'h0);
      end

      // change pulse
      rst = 1'b1;
      tick();
      rst = 1'b0; en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         sel = chg_sel[k];
         tick();
         chk($sformatf("change_step_%0d", k), {31'h0, change_q}, {31'h0, exp_chg[k]});
      end
      en = 1'b0; sel = 3'd4;
      tick();
      chk("change_idle", {31'h0, change_q}, 32'h0);
      en = 1'b1; sel = 3'd1;
      tick();
      chk("change_same_after_gap", {31'h0, change_q}, 32'h0);

      // saturation on the 4-bit instance
      rst = 1'b1; en = 1'b0;
      tick();
      rst = 1'b0; en = 1'b1; sel = 3'd7; cnt_sel = 3'd7;
      repeat (15) tick();
      chk("sat4_at15", {28'h0, cnt_out4}, 32'd15);
      repeat (5) tick();
      en = 1'b0; #1;
      chk("sat4_after20", {28'h0, cnt_out4}, 32'd15);
      chk("cnt16_after20", {16'h0, cnt_out}, 32'd20);

      // reset mid-run
      en = 1'b1; sel = 3'd3;
      repeat (2) tick();
      rst = 1'b1; en = 1'b1; clr = 1'b0; sel = 3'd6;
      tick();
      chk("mid_y_q", {24'h0, y_q}, 32'h0);
      chk("mid_valid_q", {31'h0, valid_q}, 32'h0);
      chk("mid_change_q", {31'h0, change_q}, 32'h0);
      chk("mid_y_live", {24'h0, y}, 32'h40);
      for (int i = 0; i < 8; i++) begin
         cnt_sel = 3'(i);
         #1;
         chk($sformatf("mid_cnt_%0d", i), {16'h0, cnt_out}, 32'h0);
         chk($sformatf("mid_cnt4_%0d", i), {28'h0, cnt_out4}, 32'h0);
      end
      rst = 1'b0; en = 1'b1; sel = 3'd2;
      tick();
      chk("post_rst_first_nochange", {31'h0, change_q}, 32'h0);
      chk("post_rst_y_q", {24'h0, y_q}, 32'h04);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decoder3to8.md
DECODER3TO8 -- requirements
Module: decoder3to8

Interface
REQ-001 Parameter CNT_W, default 16, width of each per-line hit counter.
REQ-002 Port clk  input  1  rising-edge clock for all registered logic.
REQ-003 Port rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 Port sel  input  3  binary select code.
REQ-005 Port y  output  8  combinational one-hot decode of sel.
REQ-006 Port en  input  1  qualifies sel for the registered path and the counters.
REQ-007 Port clr  input  1  synchronous clear of all hit counters.
REQ-008 Port y_q  output  8  registered, enable-gated decode.
REQ-009 Port valid_q  output  1  registered copy of en.
REQ-010 Port change_q  output  1  one-cycle pulse when a qualified sel differs from the last qualified sel.
REQ-011 Port cnt_sel  input  3  read index into the hit-counter bank.
REQ-012 Port cnt_out  output  CNT_W  combinational read of hit counter[cnt_sel].

Function
REQ-013 y SHALL equal 8'b0000_0001 shifted left by sel, purely combinational, with exactly one bit set for every sel value 0..7.
REQ-014 y SHALL NOT depend on clk, rst, en, clr or any state; it is valid with clk, rst, en and clr unconnected or X/Z.
REQ-015 On each rising clk with rst low, y_q SHALL load the one-hot decode of sel when en=1, else 8'h00; latency is one cycle.
REQ-016 valid_q SHALL load en each rising clk; y_q is non-zero only when valid_q=1.
REQ-017 A last-sel register SHALL load sel on every cycle with en=1 and hold otherwise; it starts flagged "empty" after reset.
REQ-018 change_q SHALL be 1 for exactly one cycle after a cycle with en=1 and sel different from the last-sel register; the first qualified sel after reset SHALL NOT pulse.
REQ-019 Eight CNT_W-bit hit counters SHALL exist, one per output line; counter[sel] SHALL increment by 1 on each cycle with en=1.
REQ-020 Hit counters SHALL saturate at all-ones and never wrap.
REQ-021 clr=1 SHALL zero all counters on that edge; clr has priority over a simultaneous increment.
REQ-022 cnt_out SHALL reflect counter[cnt_sel] combinationally, showing the post-edge value.

Reset
REQ-023 On a rising clk with rst=1, the following SHALL all clear: y_q=8'h00, valid_q=0, change_q=0, all counters=0, last-sel=0 and flagged empty.
REQ-024 rst SHALL have priority over en and clr.
REQ-025 rst asserted mid-operation SHALL discard all in-flight state on that edge.
REQ-026 y SHALL remain the live decode of sel during reset.

Structure
REQ-027 A shared package decoder3to8_pkg SHALL hold SEL_W=3, OUT_W=8 and the default CNT_W.
REQ-028 A sub-module sat_counter (CNT_W-bit, with inc, clr and rst inputs, saturating) SHALL be instantiated eight times.
REQ-029 All other logic SHALL reside in decoder3to8.

Verification
REQ-030 Combinational sweep: clk, rst and en idle; sel=0..7, checking y after 1 ns at each step -> y=01,02,04,08,10,20,40,80 (hex) with no mismatch.
REQ-031 Registered path: rst then en=1, sel=5 for one edge -> y_q=8'h20 and valid_q=1 next cycle; en=0 -> y_q=8'h00 and valid_q=0.
REQ-032 Counters: en=1, sel=3 held for 4 edges -> cnt_sel=3 gives cnt_out=4 and cnt_sel=2 gives 0; then clr with en=1 -> all counters 0.
REQ-033 Saturation: CNT_W=4, sel=7 with en=1 for 20 edges -> cnt_out=15 with cnt_sel=7.
REQ-034 change_q: qualified sel sequence 2,2,6,6,1 after reset -> change_q pulses only after the 6 and the 1, with no pulse for the first 2.
REQ-035 Reset mid-run: counters non-zero, then rst=1 together with en=1 and clr=0 -> all registered outputs and counters 0, while y still decodes sel.
